// File: rtl/reg_dump_if.sv
// Register-dump port bundle: start/stall handshake,
// register file read port, byte stream and status.
interface reg_dump_if;
    logic        start;
    logic        stall_req;
    logic        stall_ack;
    logic [3:0]  rno;
    logic [31:0] rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        busy;
    logic        done;

    modport master (
        input  start, stall_ack, rdata, tx_ready,
        output stall_req, rno, tx_valid, tx_data, busy, done
    );

    modport slave (
        output start, stall_ack, rdata, tx_ready,
        input  stall_req, rno, tx_valid, tx_data, busy, done
    );
endinterface

// File: rtl/reg_dump.sv
// Register file dump: freeze CPU writes, snapshot regs 0..LAST,
// then stream HDR, register bytes (LSB first) and an XOR checksum.
module reg_dump #(
    parameter int         LAST = 15,
    parameter logic [7:0] HDR  = 8'hA5
) (
    input logic        clk,
    input logic        rst,
    reg_dump_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQ, SNAP, SEND, FIN} state_t;

    localparam int         NB     = 4 * (LAST + 1) + 2;
    localparam logic [6:0] B_CS   = 7'(NB - 2);
    localparam logic [6:0] B_END  = 7'(NB - 1);
    localparam logic [3:0] R_LAST = 4'(LAST);

    state_t      st;
    logic        stall_req_q;
    logic [3:0]  rno_q;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;
    logic        busy_q;
    logic        done_q;
    logic [6:0]  bcnt;
    logic [7:0]  csum;
    logic [31:0] snap_q [0:LAST];
    logic [31:0] wsel;
    logic [7:0]  nxt_byte;
    logic [7:0]  rd_xor;

    assign bus.stall_req = stall_req_q;
    assign bus.rno       = rno_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    // Byte following the one at bcnt: register byte, or the checksum last
    always_comb begin
        wsel     = snap_q[bcnt[5:2]];
        rd_xor   = bus.rdata[7:0] ^ bus.rdata[15:8]
                 ^ bus.rdata[23:16] ^ bus.rdata[31:24];
        nxt_byte = wsel[{bcnt[1:0], 3'b000} +: 8];
        if (bcnt == B_CS) begin
            nxt_byte = csum;
        end
    end

    // Snapshot buffer; contents are always rewritten before being sent
    always_ff @(posedge clk) begin
        if (st == SNAP) begin
            snap_q[rno_q] <= bus.rdata;
        end
    end

    // Dump sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= IDLE;
            stall_req_q <= 1'b0;
            rno_q       <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bcnt        <= '0;
            csum        <= '0;
        end else begin
            unique case (st)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        st          <= REQ;
                        busy_q      <= 1'b1;
                        stall_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.stall_ack) begin
                        st    <= SNAP;
                        rno_q <= '0;
                        csum  <= '0;
                    end
                end
                SNAP: begin
                    csum <= csum ^ rd_xor;
                    if (rno_q == R_LAST) begin
                        st          <= SEND;
                        stall_req_q <= 1'b0;
                        rno_q       <= '0;
                        tx_valid_q  <= 1'b1;
                        tx_data_q   <= HDR;
                        bcnt        <= '0;
                    end else begin
                        rno_q <= rno_q + 4'd1;
                    end
                end
                SEND: begin
                    if (bus.tx_ready) begin
                        if (bcnt == B_END) begin
                            st         <= FIN;
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= '0;
                            done_q     <= 1'b1;
                        end else begin
                            bcnt      <= bcnt + 7'd1;
                            tx_data_q <= nxt_byte;
                        end
                    end
                end
                FIN: begin
                    st     <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    bcnt   <= '0;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: table of dump scenarios plus
// hand-written reset sequences.
module tb_reg_dump;
    logic clk = 1'b0;
    logic rst;
    logic [31:0] regs [0:15];
    int n_chk = 0;
    int n_fail = 0;

    reg_dump_if bus ();

    reg_dump #(.LAST(15), .HDR(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rdata = regs[bus.rno];

    always #5 clk = ~clk;

    typedef struct {
        int         pat;
        int         ack_delay;
        bit         toggle;
        bit         ack_drop;
        bit         wr_send;
        bit         start_mid;
        int         chk_idx;
        logic [7:0] chk_val;
        logic [7:0] csum;
        int         cycles;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load(input int pat);
        for (int r = 0; r < 16; r++) begin
            regs[r] = '0;
            if (pat == 0) regs[r] = 32'h01010101 * r;
        end
        if (pat == 1) regs[1] = 32'h12345678;
        if (pat == 2) regs[7] = 32'hA1B2C3D4;
    endtask

    task automatic run(input vec_t v);
        logic [7:0] exp [$];
        logic [7:0] got [$];
        logic [7:0] x;
        logic [7:0] hd;
        logic       hold;
        int         cyc;
        int         bubbles;
        int         unstable;
        int         nbad;
        load(v.pat);
        x = '0;
        exp.push_back(8'hA5);
        for (int r = 0; r < 16; r++) begin
            for (int b = 0; b < 4; b++) begin
                exp.push_back(regs[r][8*b +: 8]);
                x ^= regs[r][8*b +: 8];
            end
        end
        exp.push_back(x);
        @(negedge clk);
        bus.start = 1'b1;
        bus.stall_ack = 1'b0;
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("req_busy", bus.busy, 1);
        repeat (v.ack_delay) begin
            check("wait_stall", bus.stall_req, 1);
            check("wait_rno", bus.rno, 0);
            check("wait_valid", bus.tx_valid, 0);
            @(negedge clk);
        end
        bus.stall_ack = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("snap_rno", bus.rno, k);
            check("snap_stall", bus.stall_req, 1);
            check("snap_valid", bus.tx_valid, 0);
            if (v.ack_drop && k == 3) bus.stall_ack = 1'b0;
        end
        @(negedge clk);
        check("send_stall", bus.stall_req, 0);
        check("send_valid", bus.tx_valid, 1);
        check("send_hdr", bus.tx_data, 8'hA5);
        check("send_rno", bus.rno, 0);
        if (v.wr_send) regs[3] = 32'hDEADBEEF;
        bubbles = 0;
        unstable = 0;
        hold = 1'b0;
        hd = '0;
        cyc = 0;
        for (cyc = 0; cyc < 400; cyc++) begin
            if (bus.done) break;
            if (v.toggle) bus.tx_ready = (cyc % 2 == 0);
            if (v.start_mid) bus.start = (cyc == 5);
            if (!bus.tx_valid) bubbles++;
            if (hold && (!bus.tx_valid || bus.tx_data !== hd)) unstable++;
            if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
            hold = bus.tx_valid && !bus.tx_ready;
            hd = bus.tx_data;
            @(negedge clk);
        end
        bus.tx_ready = 1'b1;
        bus.start = 1'b0;
        check("cycles", cyc, v.cycles);
        check("bubbles", bubbles, 0);
        check("unstable", unstable, 0);
        check("fin_done", bus.done, 1);
        check("fin_valid", bus.tx_valid, 0);
        check("fin_busy", bus.busy, 1);
        check("len", got.size(), 66);
        nbad = 0;
        for (int i = 0; i < got.size() && i < 66; i++) begin
            if (got[i] !== exp[i]) nbad++;
        end
        check("stream", nbad, 0);
        if (got.size() > v.chk_idx) begin
            check("byte_pick", got[v.chk_idx], v.chk_val);
            check("csum", got[got.size()-1], v.csum);
        end else begin
            check("short_stream", got.size(), 66);
        end
        @(negedge clk);
        check("idle_done", bus.done, 0);
        check("idle_busy", bus.busy, 0);
        @(negedge clk);
        check("no_queue", bus.stall_req, 0);
        check("no_queue_busy", bus.busy, 0);
    endtask

    initial begin
        int n;
        tbl[0] = '{0, 0,  1'b0, 1'b0, 1'b0, 1'b0, 5,  8'h01, 8'h00, 66};
        tbl[1] = '{1, 0,  1'b0, 1'b0, 1'b0, 1'b0, 5,  8'h78, 8'h08, 66};
        tbl[2] = '{1, 10, 1'b0, 1'b1, 1'b0, 1'b0, 8,  8'h12, 8'h08, 66};
        tbl[3] = '{0, 0,  1'b1, 1'b0, 1'b0, 1'b0, 64, 8'h0F, 8'h00, 131};
        tbl[4] = '{2, 0,  1'b0, 1'b0, 1'b0, 1'b1, 29, 8'hD4, 8'h04, 66};
        tbl[5] = '{1, 0,  1'b0, 1'b0, 1'b1, 1'b0, 13, 8'h00, 8'h08, 66};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.stall_ack = 1'b0;
        bus.tx_ready = 1'b1;
        load(0);
        repeat (2) @(negedge clk);
        check("rst_stall", bus.stall_req, 0);
        check("rst_rno", bus.rno, 0);
        check("rst_valid", bus.tx_valid, 0);
        check("rst_data", bus.tx_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        rst = 1'b0;

        for (int t = 0; t < 6; t++) run(tbl[t]);

        // reset in the middle of the snapshot
        load(0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.stall_ack = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("midsnap_rno_live", bus.rno, 3);
        rst = 1'b1;
        @(negedge clk);
        check("midsnap_stall", bus.stall_req, 0);
        check("midsnap_rno", bus.rno, 0);
        check("midsnap_busy", bus.busy, 0);
        rst = 1'b0;

        // reset after 10 bytes of a stream
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        for (int c = 0; c < 200 && n < 10; c++) begin
            if (bus.tx_valid && bus.tx_ready) n++;
            @(negedge clk);
        end
        check("sent10", n, 10);
        check("midsend_valid_live", bus.tx_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midsend_valid", bus.tx_valid, 0);
        check("midsend_busy", bus.busy, 0);
        check("midsend_data", bus.tx_data, 0);
        rst = 1'b0;
        run(tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
